// File: rtl/afh_map_scheduler.sv
// Rebuilds the AFH channel map: scans 79 channels in basic-hop order, writes used channels into the
// inactive remap-table bank, then atomically swaps map/N/bank when at least 20 channels are used.
module afh_map_scheduler (
  input  logic        clk,
  input  logic        rstz,
  input  logic        start,
  input  logic [79:0] chmap_in,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [79:0] regi_AFH_channel_map,
  output logic [6:0]  regi_AFH_modN,
  output logic        map_valid,
  output logic        tbl_bank,
  output logic        tbl_we,
  output logic        tbl_wbank,
  output logic [6:0]  tbl_waddr,
  output logic [6:0]  tbl_wdata
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state, state_nxt;
  logic [79:0] shadow;
  logic [6:0]  idx;
  logic [6:0]  cnt;
  logic [6:0]  ch;
  logic        hit;
  logic        last;

  // Even channels first (0,2,..,78), then odd ones (1,3,..,77).
  always_comb begin
    ch = 7'd0;
    if (idx <= 7'd39) begin
      ch = {idx[5:0], 1'b0};
    end else begin
      ch = {6'(idx - 7'd40), 1'b1};
    end
  end

  assign hit       = shadow[ch];
  assign last      = (idx == 7'd78);
  assign tbl_wbank = ~tbl_bank;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) begin
      shadow               <= 80'h0;
      idx                  <= 7'd0;
      cnt                  <= 7'd0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      cfg_err              <= 1'b0;
      tbl_we               <= 1'b0;
      tbl_waddr            <= 7'd0;
      tbl_wdata            <= 7'd0;
      tbl_bank             <= 1'b0;
      map_valid            <= 1'b0;
      regi_AFH_modN        <= 7'd79;
      regi_AFH_channel_map <= 80'h0;
    end else begin
      // Status strobes lag the state by one cycle so all outputs are registered.
      busy    <= (state != IDLE);
      done    <= (state == DONE);
      cfg_err <= (state == DONE) && (cnt < 7'd20);
      tbl_we  <= (state == SCAN) && hit;
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= chmap_in;
            idx    <= 7'd0;
            cnt    <= 7'd0;
          end
        end
        SCAN: begin
          if (hit) begin
            tbl_waddr <= cnt;
            tbl_wdata <= ch;
            if (cnt != 7'd79) cnt <= cnt + 7'd1;
          end
          if (!last) idx <= idx + 7'd1;
        end
        DONE: begin
          // Map, N and bank swap together so the hop kernel never sees a mixed set.
          if (cnt >= 7'd20) begin
            regi_AFH_channel_map <= {1'b0, shadow[78:0]};
            regi_AFH_modN        <= cnt;
            tbl_bank             <= ~tbl_bank;
            map_valid            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_afh_map_scheduler.sv
// Scoreboard bench for afh_map_scheduler: expected table writes are queued at start, popped on tbl_we.
module tb_afh_map_scheduler;

  logic        clk = 1'b0;
  logic        rstz;
  logic        start;
  logic [79:0] chmap_in;
  logic        busy, done, cfg_err, map_valid, tbl_bank, tbl_we, tbl_wbank;
  logic [79:0] regi_AFH_channel_map;
  logic [6:0]  regi_AFH_modN, tbl_waddr, tbl_wdata;

  int total = 0;
  int bad   = 0;

  logic [13:0] wq[$];
  logic [79:0] exp_map;
  logic [6:0]  exp_modn;
  logic        exp_bank;
  logic        exp_valid;

  afh_map_scheduler dut (
    .clk                  (clk),
    .rstz                 (rstz),
    .start                (start),
    .chmap_in             (chmap_in),
    .busy                 (busy),
    .done                 (done),
    .cfg_err              (cfg_err),
    .regi_AFH_channel_map (regi_AFH_channel_map),
    .regi_AFH_modN        (regi_AFH_modN),
    .map_valid            (map_valid),
    .tbl_bank             (tbl_bank),
    .tbl_we               (tbl_we),
    .tbl_wbank            (tbl_wbank),
    .tbl_waddr            (tbl_waddr),
    .tbl_wdata            (tbl_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    exp_map   = 80'h0;
    exp_modn  = 7'd79;
    exp_bank  = 1'b0;
    exp_valid = 1'b0;
    chk({tag, "_busy"},    busy,                 0);
    chk({tag, "_done"},    done,                 0);
    chk({tag, "_cfgerr"},  cfg_err,              0);
    chk({tag, "_we"},      tbl_we,               0);
    chk({tag, "_waddr"},   tbl_waddr,            0);
    chk({tag, "_wdata"},   tbl_wdata,            0);
    chk({tag, "_bank"},    tbl_bank,             0);
    chk({tag, "_wbank"},   tbl_wbank,            1);
    chk({tag, "_valid"},   map_valid,            0);
    chk({tag, "_modn"},    regi_AFH_modN,        79);
    chk({tag, "_map"},     regi_AFH_channel_map, 0);
  endtask

  task automatic check_active(input string tag);
    chk({tag, "_map"},   regi_AFH_channel_map, exp_map);
    chk({tag, "_modn"},  regi_AFH_modN,        exp_modn);
    chk({tag, "_bank"},  tbl_bank,             exp_bank);
    chk({tag, "_valid"}, map_valid,            exp_valid);
  endtask

  // rst_at > 0 aborts the scan with a reset pulse in that cycle.
  task automatic run_scan(input string tag, input logic [79:0] m, input int restart_at, input int rst_at);
    int          n;
    int          c;
    logic [13:0] w;
    wq.delete();
    n = 0;
    for (int i = 0; i < 79; i++) begin
      c = (i <= 39) ? 2 * i : 2 * (i - 40) + 1;
      if (m[c]) begin
        wq.push_back({7'(n), 7'(c)});
        n++;
      end
    end
    @(negedge clk);
    chmap_in = m;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 81; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == rst_at) begin
        rstz = 1'b1;
        #1 check_reset({tag, "_abort"});
        @(negedge clk);
        rstz = 1'b0;
        wq.delete();
        return;
      end
      if (tbl_we) begin
        if (wq.size() == 0) begin
          chk({tag, "_extra_wr"}, {tbl_waddr, tbl_wdata}, 0);
          total--;
          chk({tag, "_extra_wr_flag"}, 1, 0);
        end else begin
          w = wq.pop_front();
          chk({tag, "_wr"},    {tbl_waddr, tbl_wdata}, w);
          chk({tag, "_wbank"}, tbl_wbank, !exp_bank);
        end
      end
      chk({tag, "_busy"},   busy,    cyc <= 80);
      chk({tag, "_done"},   done,    cyc == 80);
      chk({tag, "_cfgerr"}, cfg_err, (cyc == 80) && (n < 20));
      if (cyc == 80 && n >= 20) begin
        exp_map   = {1'b0, m[78:0]};
        exp_modn  = 7'(n);
        exp_bank  = !exp_bank;
        exp_valid = 1'b1;
      end
      check_active(tag);
      if (cyc == 10) chmap_in = ~m;
      if (cyc == restart_at - 1) start = 1'b1;
      if (cyc == restart_at) start = 1'b0;
    end
    chk({tag, "_leftover"}, wq.size(), 0);
  endtask

  initial begin
    rstz     = 1'b1;
    start    = 1'b0;
    chmap_in = 80'h0;
    #12 check_reset("por");
    @(negedge clk);
    rstz = 1'b0;

    run_scan("all",    80'h7FFF_FFFF_FFFF_FFFF_FFFF, 0, 0);
    chk("all_modn_79", regi_AFH_modN, 79);
    chk("all_bank_1",  tbl_bank,      1);
    run_scan("b0_19",  80'hF_FFFF, 0, 0);
    chk("b0_19_modn",  regi_AFH_modN, 20);
    run_scan("b0_18",  80'h7_FFFF, 0, 0);
    chk("b0_18_modn",  regi_AFH_modN, 20);
    run_scan("b79",    80'h8000_0000_0000_0000_0000, 30, 0);
    run_scan("abort",  80'h7FFF_FFFF_FFFF_FFFF_FFFF, 0, 40);
    run_scan("post",   {16'($urandom), $urandom, $urandom} | 80'hF_FFFF, 0, 0);
    chk("post_valid",  map_valid, 1);
    chk("post_bank",   tbl_bank,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afh_map_scheduler.md
AFH_MAP_SCHEDULER -- requirements
Module: afh_map_scheduler

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all state.
REQ-002 SHALL have port rstz, input, 1 bit: asynchronous, active-high reset; reset is asserted when rstz=1.
REQ-003 SHALL have port start, input, 1 bit: request to rebuild the AFH map from chmap_in.
REQ-004 SHALL have port chmap_in, input, 80 bits: candidate channel map; bit c=1 means RF channel c is used; bit 79 is reserved and ignored.
REQ-005 SHALL have port busy, output, 1 bit: scan in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a scan.
REQ-007 SHALL have port cfg_err, output, 1 bit: one-cycle pulse with done when the used-channel count is below 20.
REQ-008 SHALL have port regi_AFH_channel_map, output, 80 bits: active channel map that feeds the hop kernel.
REQ-009 SHALL have port regi_AFH_modN, output, 7 bits: active used-channel count N.
REQ-010 SHALL have port map_valid, output, 1 bit: active map and table are consistent and N>=20.
REQ-011 SHALL have port tbl_bank, output, 1 bit: selects the active remap-table bank that the hop kernel reads.
REQ-012 SHALL have port tbl_we, output, 1 bit: write strobe into the remap table.
REQ-013 SHALL have port tbl_wbank, output, 1 bit: bank being written; always equals ~tbl_bank.
REQ-014 SHALL have port tbl_waddr, output, 7 bits: remap index k.
REQ-015 SHALL have port tbl_wdata, output, 7 bits: RF channel stored at index k.

Function
REQ-016 SHALL implement the states IDLE, SCAN and DONE.
REQ-017 In IDLE, start=1 SHALL latch chmap_in into a shadow register, clear the scan index i and the count n to 0, and move to SCAN.
REQ-018 start SHALL be ignored in SCAN and DONE; requests are not queued.
REQ-019 SCAN SHALL last exactly 79 cycles, i = 0..78, with one index per cycle.
REQ-020 SHALL map scan index i to channel ch(i) in basic-hop order: i<=39 gives ch=2i; i>=40 gives ch=2(i-40)+1, so the order is 0,2,...,78,1,3,...,77.
REQ-021 For each i with shadow[ch(i)]=1, SHALL drive tbl_we=1, tbl_waddr=n, tbl_wdata=ch(i) for one cycle, then increment n; otherwise tbl_we SHALL be 0.
REQ-022 Write-port outputs SHALL be registered; writes SHALL occur in cycles 1..79, where cycle 0 is the clock edge that samples start.
REQ-023 n SHALL be 7 bits and saturate at 79 (max 79 used channels); no wrap-around.
REQ-024 After i=78, the block SHALL enter DONE for exactly one cycle (cycle 80), then return to IDLE in cycle 81.
REQ-025 In DONE with n>=20: regi_AFH_channel_map <= shadow with bit79 forced to 0, regi_AFH_modN <= n, tbl_bank toggles, map_valid <= 1, done=1.
REQ-026 In DONE with n<20: done=1 and cfg_err=1; regi_AFH_channel_map, regi_AFH_modN, tbl_bank and map_valid SHALL be unchanged.
REQ-027 busy SHALL be 1 in cycles 1..80 and 0 otherwise.
REQ-028 Active outputs SHALL change only in DONE, all in the same cycle, so the hop kernel never sees a mixed map/N/bank.
REQ-029 Writes SHALL target only the inactive bank; the active bank SHALL never be written.
REQ-030 chmap_in changes during SCAN SHALL have no effect on the scan in progress.

Reset
REQ-031 While rstz=1, asynchronously: state=IDLE, i=0, n=0, busy=0, done=0, cfg_err=0, tbl_we=0, tbl_waddr=0, tbl_wdata=0.
REQ-032 While rstz=1, asynchronously: tbl_bank=0, tbl_wbank=1, map_valid=0, regi_AFH_modN=79, regi_AFH_channel_map=80'h0.
REQ-033 Reset asserted mid-scan SHALL abort the scan; partial writes are discarded and the block stays invalid until the next good scan.

Verification
REQ-034 chmap_in=80'h7FFF_FFFF_FFFF_FFFF_FFFF, start pulse -> 79 writes with (addr,data) = (0,0),(39,78),(40,1),(78,77); done at cycle 80; modN=79; map_valid=1; tbl_bank toggles to 1.
REQ-035 chmap_in bits 0..19 set -> 20 writes: addr 0..9 with data 0,2,...,18 and addr 10..19 with data 1,3,...,19; modN=20; map_valid=1; cfg_err=0.
REQ-036 chmap_in bits 0..18 set after a good map -> 19 writes; done=1 and cfg_err=1 at cycle 80; modN, active map, tbl_bank and map_valid unchanged.
REQ-037 Only bit 79 set -> 0 writes; cfg_err=1. Second start issued at cycle 30 -> ignored, single done at cycle 80, busy low at cycle 81.
REQ-038 rstz pulsed at cycle 40 of a scan -> all outputs take the REQ-031/REQ-032 values immediately; a new start then completes normally with done 80 cycles later.
